// File: rtl/pwm_wave_gen.sv
// Phase-accumulator PWM generator with phase offset and duty threshold.
// Define PWM_WAVE_GEN_SHADOW_EN to defer step/phase/duty changes to the period wrap.
module pwm_wave_gen #(
  parameter int unsigned ACC_W = 23,
  parameter int unsigned PH_W  = 7,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] step,
  input  logic [PH_W-1:0]  phase,
  input  logic [PH_W:0]    duty,
  input  logic             load,
  output logic [OUT_W-1:0] pwm_out,
  output logic             period_tick
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_step_a;
  logic [PH_W-1:0]  r_phase_a;
  logic [PH_W:0]    r_duty_a;

  logic [ACC_W:0]   w_sum;
  logic             w_wrap;
  logic [PH_W-1:0]  w_idx;
  logic             w_high;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_step_a};
  assign w_wrap = enable & w_sum[ACC_W];
  // Index wraps mod 2^PH_W; the PH_W+1-bit compare makes duty >= 2^PH_W always high.
  assign w_idx  = r_acc[ACC_W-1 -: PH_W] + r_phase_a;
  assign w_high = ({1'b0, w_idx} < r_duty_a);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else if (enable) begin
      r_acc       <= w_sum[ACC_W-1:0];
      pwm_out     <= w_high ? '1 : '0;
      period_tick <= w_sum[ACC_W];
    end else begin
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end
  end

`ifdef PWM_WAVE_GEN_SHADOW_EN
  logic [ACC_W-1:0] r_step_p;
  logic [PH_W-1:0]  r_phase_p;
  logic [PH_W:0]    r_duty_p;
  logic             r_pend_vld;
  logic             w_commit;

  // While stopped there is no wrap, so a fresh load is committed on the following edge.
  assign w_commit = w_wrap | (~enable & r_pend_vld);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_a   <= '0;
      r_phase_a  <= '0;
      r_duty_a   <= '0;
      r_step_p   <= '0;
      r_phase_p  <= '0;
      r_duty_p   <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_commit) begin
        r_step_a  <= r_step_p;
        r_phase_a <= r_phase_p;
        r_duty_a  <= r_duty_p;
      end
      if (load) begin
        r_step_p   <= step;
        r_phase_p  <= phase;
        r_duty_p   <= duty;
        r_pend_vld <= 1'b1;
      end else if (w_commit) begin
        r_pend_vld <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_a  <= '0;
      r_phase_a <= '0;
      r_duty_a  <= '0;
    end else if (load) begin
      r_step_a  <= step;
      r_phase_a <= phase;
      r_duty_a  <= duty;
    end
  end
`endif

endmodule
